mem_page_reader: RTL and testbench

- Downstream consumer of the paged dual-port BRAM stage.
- On a start pulse it:
  - fetches the entry count for one page from the memory's per-page count output;
  - sweeps read addresses 0..nent-1 on that page;
  - absorbs the memory's fixed read latency;
  - streams the entries out on a valid/ready interface.
- Backpressure uses a credit-checked skid FIFO, so no entry is lost or duplicated.

---
 rtl/mem_page_reader_if.sv | 36 +++
 rtl/mem_page_reader.sv | 210 +++++++++++++++++++++
 tb/tb_mem_page_reader.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_page_reader_if.sv
// Bus bundle between mem_page_reader, the paged read port of the BRAM
// stage and the downstream entry consumer. The master view is the reader;
// the slave view is everything the reader talks to (memory plus sink).
interface mem_page_reader_if #(
    parameter int RAM_WIDTH = 18,
    parameter int AW        = 10,
    parameter int PW        = 1
);
    // memory read port
    logic [AW-1:0]        addrb;
    logic [PW-1:0]        pageb;
    logic                 enb;
    logic                 regceb;
    logic                 rstb;
    logic [4:0]           nent_in;
    logic [RAM_WIDTH-1:0] doutb;
    // streamed entry output
    logic [RAM_WIDTH-1:0] dout;
    logic                 dout_valid;
    logic                 dout_ready;
    logic                 dout_last;

    modport master (
        output addrb, pageb, enb, regceb, rstb,
        input  nent_in, doutb,
        output dout, dout_valid, dout_last,
        input  dout_ready
    );

    modport slave (
        input  addrb, pageb, enb, regceb, rstb,
        output nent_in, doutb,
        input  dout, dout_valid, dout_last,
        output dout_ready
    );
endinterface

// File: rtl/mem_page_reader.sv
// Page reader: fetches a page's entry count, sweeps its read addresses,
// absorbs the fixed memory latency and streams entries through a
// credit-checked show-ahead skid FIFO.

// Invariant checker for the skid FIFO (never pushed while full).
module mem_page_reader_chk #(
    parameter int FIFO_DEPTH = 4,
    parameter int CW         = 3
) (
    input logic          clk,
    input logic          rst_n,
    input logic          i_push,
    input logic [CW-1:0] i_cnt
);
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(i_push && (i_cnt == CW'(FIFO_DEPTH))));
endmodule

module mem_page_reader #(
    parameter  int RAM_WIDTH  = 18,
    parameter  int RAM_DEPTH  = 1024,
    parameter  int PAGES      = 2,
    parameter  int RD_LATENCY = 2,
    parameter  int FIFO_DEPTH = 4,
    localparam int AW         = $clog2(RAM_DEPTH),
    localparam int PW         = PAGES / 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [PW-1:0] page_i,
    output logic          busy,
    output logic          done,
    mem_page_reader_if.master bus
);
    localparam int FW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_WAITN = 3'd2;
    localparam logic [2:0] S_READ  = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    // Number of reads still travelling through the memory latency.
    function automatic logic [7:0] f_ones(input logic [RD_LATENCY-1:0] v);
        logic [7:0] n;
        n = 8'd0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            n = n + {7'd0, v[i]};
        end
        return n;
    endfunction

    logic [2:0]           r_state;
    logic                 r_busy;
    logic                 r_done;
    logic [PW-1:0]        r_page;
    logic [4:0]           r_nent;
    logic [4:0]           r_rd_cnt;
    logic [AW-1:0]        r_addrb;
    logic [RD_LATENCY-1:0] r_pipe;
    logic [RAM_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [FW-1:0]        r_wr_ptr;
    logic [FW-1:0]        r_rd_ptr;
    logic [CW-1:0]        r_cnt;
    logic [4:0]           r_idx;

    logic [2:0]           w_state_nx;
    logic                 w_issue;
    logic                 w_accept;
    logic [4:0]           w_rd_next;
    logic [7:0]           w_used;
    logic                 w_credit_ok;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_valid;
    logic                 w_last;
    logic                 w_drained;

    assign w_accept    = (r_state == S_IDLE) && start;
    assign w_rd_next   = r_rd_cnt + 5'd1;
    // Pops in the current cycle are deliberately not credited back.
    assign w_used      = f_ones(r_pipe) + 8'(r_cnt);
    assign w_credit_ok = (w_used < 8'(FIFO_DEPTH));
    assign w_push      = r_pipe[RD_LATENCY-1];
    assign w_valid     = (r_cnt != CW'(0));
    assign w_pop       = w_valid && bus.dout_ready;
    assign w_last      = (r_idx == (r_nent - 5'd1));
    // Done once nothing is in flight and the final entry handshakes now.
    assign w_drained   = (r_pipe == '0) &&
                         (((r_cnt == CW'(0)) && (r_idx == r_nent)) ||
                          (w_pop && (r_cnt == CW'(1)) && w_last));

    // Next-state and address-issue decision.
    always_comb begin
        w_state_nx = r_state;
        w_issue    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_nx = S_FETCH;
                else       w_state_nx = S_IDLE;
            end
            S_FETCH: w_state_nx = S_WAITN;
            S_WAITN: begin
                if (bus.nent_in == 5'd0) w_state_nx = S_DONE;
                else                     w_state_nx = S_READ;
            end
            S_READ: begin
                if (w_credit_ok) begin
                    w_issue = 1'b1;
                    if (w_rd_next == r_nent) w_state_nx = S_DRAIN;
                    else                     w_state_nx = S_READ;
                end else begin
                    w_state_nx = S_READ;
                end
            end
            S_DRAIN: begin
                if (w_drained) w_state_nx = S_DONE;
                else           w_state_nx = S_DRAIN;
            end
            S_DONE:  w_state_nx = S_IDLE;
            default: w_state_nx = S_IDLE;
        endcase
    end

    // Control registers: state, status flags, page/count capture, address sweep.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_page   <= '0;
            r_nent   <= 5'd0;
            r_rd_cnt <= 5'd0;
            r_addrb  <= '0;
        end else begin
            r_state <= w_state_nx;
            r_busy  <= (w_state_nx == S_FETCH) || (w_state_nx == S_WAITN) ||
                       (w_state_nx == S_READ)  || (w_state_nx == S_DRAIN);
            r_done  <= (w_state_nx == S_DONE);
            if (w_accept) begin
                r_page   <= page_i;
                r_rd_cnt <= 5'd0;
                r_addrb  <= '0;
            end else if (r_state == S_WAITN) begin
                r_nent   <= bus.nent_in;
                r_rd_cnt <= 5'd0;
                r_addrb  <= '0;
            end else if (w_issue) begin
                r_rd_cnt <= w_rd_next;
                // Address stays on the last valid entry once the sweep ends.
                if (w_rd_next < r_nent) r_addrb <= AW'(w_rd_next);
                else                    r_addrb <= r_addrb;
            end else begin
                r_rd_cnt <= r_rd_cnt;
                r_addrb  <= r_addrb;
            end
        end
    end

    // Read-latency valid pipe, skid FIFO storage/pointers and pop index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pipe   <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
            r_idx    <= 5'd0;
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
        end else begin
            r_pipe[0] <= w_issue;
            for (int i = 1; i < RD_LATENCY; i++) r_pipe[i] <= r_pipe[i-1];
            if (w_push) begin
                r_mem[r_wr_ptr] <= bus.doutb;
                r_wr_ptr <= (r_wr_ptr == FW'(FIFO_DEPTH - 1)) ? '0 : r_wr_ptr + FW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == FW'(FIFO_DEPTH - 1)) ? '0 : r_rd_ptr + FW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + CW'(1);
                2'b01:   r_cnt <= r_cnt - CW'(1);
                default: r_cnt <= r_cnt;
            endcase
            if (w_accept)   r_idx <= 5'd0;
            else if (w_pop) r_idx <= r_idx + 5'd1;
            else            r_idx <= r_idx;
        end
    end

    assign bus.addrb      = r_addrb;
    assign bus.pageb      = r_page;
    assign bus.enb        = r_busy;
    assign bus.regceb     = r_busy;
    assign bus.rstb       = 1'b0;
    assign bus.dout       = r_mem[r_rd_ptr];
    assign bus.dout_valid = w_valid;
    assign bus.dout_last  = w_valid && w_last;
    assign busy           = r_busy;
    assign done           = r_done;

    mem_page_reader_chk #(.FIFO_DEPTH(FIFO_DEPTH), .CW(CW)) u_chk (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_push (w_push),
        .i_cnt  (r_cnt)
    );
endmodule

// File: tb/tb_mem_page_reader.sv
// Bench for mem_page_reader: behavioural paged BRAM (count register plus
// two-stage read pipeline) and an expected-entry queue per started page.
module tb_mem_page_reader;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [0:0] page_i;
    logic       busy;
    logic       done;

    mem_page_reader_if #(.RAM_WIDTH(18), .AW(10), .PW(1)) bus ();

    mem_page_reader dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .page_i (page_i),
        .busy   (busy),
        .done   (done),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int popped = 0;
    logic [17:0] mem_pg [2][32];
    logic [4:0]  cnt_pg [2];
    logic [17:0] stage1;
    logic [17:0] exp_q [$];
    int          exp_page = 0;
    int          exp_nent = 0;
    bit          prev_stall = 1'b0;
    logic [17:0] prev_dout = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Memory model: count register and data both load while enb is high.
    always @(posedge clk) begin
        if (bus.enb === 1'b1) begin
            bus.nent_in <= cnt_pg[bus.pageb];
            stage1      <= mem_pg[bus.pageb][bus.addrb[4:0]];
        end
        if (bus.regceb === 1'b1) bus.doutb <= stage1;
    end

    // Stream scoreboard and interface invariants, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (done) done_cnt++;
            if (bus.enb) begin
                chk("pageb", 32'(bus.pageb), 32'(exp_page));
                if (exp_nent != 0) chk("addr_range", 32'(bus.addrb < 10'(exp_nent)), 32'd1);
            end
            if (prev_stall) begin
                chk("stall_valid", 32'(bus.dout_valid), 32'd1);
                chk("stall_data", 32'(bus.dout), 32'(prev_dout));
            end
            if (!bus.dout_valid) chk("last_idle", 32'(bus.dout_last), 32'd0);
            if (bus.dout_valid && bus.dout_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_entry", 32'd1, 32'd0);
                end else begin
                    chk("data", 32'(bus.dout), 32'(exp_q[0]));
                    chk("last", 32'(bus.dout_last), 32'(exp_q.size() == 1));
                    void'(exp_q.pop_front());
                    popped++;
                end
            end
            prev_stall = bus.dout_valid && !bus.dout_ready;
            prev_dout  = bus.dout;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic expect_page(input int pg);
        for (int i = 0; i < int'(cnt_pg[pg]); i++) exp_q.push_back(mem_pg[pg][i]);
        exp_page = pg;
        exp_nent = int'(cnt_pg[pg]);
    endtask

    task automatic fill_random(input int pg, input int n);
        for (int i = 0; i < 32; i++) mem_pg[pg][i] = 18'($urandom);
        cnt_pg[pg] = 5'(n);
    endtask

    // Start pulse in "cycle 0"; returns just after the accepting edge.
    task automatic pulse_start(input int pg);
        @(negedge clk);
        start  = 1'b1;
        page_i = 1'(pg);
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int base;
        base = done_cnt;
        for (int k = 0; k < budget && done_cnt == base; k++) @(negedge clk);
        @(negedge clk);
        chk({tag, "_done"}, 32'(done_cnt - base), 32'd1);
        chk({tag, "_all_delivered"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_popped(input string tag, input int target, input int budget);
        for (int k = 0; k < budget && popped < target; k++) @(negedge clk);
        chk({tag, "_progress"}, 32'(popped >= target), 32'd1);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_ctl"}, {18'd0, bus.addrb, bus.pageb, bus.enb, bus.regceb, bus.rstb},
            32'd0);
        chk({tag, "_strm"}, {12'd0, bus.dout, bus.dout_valid, bus.dout_last}, 32'd0);
        chk({tag, "_stat"}, {30'd0, busy, done}, 32'd0);
    endtask

    initial begin
        int base;
        rst_n          = 1'b0;
        start          = 1'b0;
        page_i         = 1'b0;
        bus.dout_ready = 1'b0;
        for (int p = 0; p < 2; p++) fill_random(p, 0);

        // Reset state, during and after release.
        repeat (3) @(posedge clk);
        #1 chk_outputs_zero("rst_hold");
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk_outputs_zero("rst_release");

        // Directed: page 0 with three entries, exact cycle timing.
        mem_pg[0][0] = 18'h00011;
        mem_pg[0][1] = 18'h00022;
        mem_pg[0][2] = 18'h00033;
        cnt_pg[0]    = 5'd3;
        expect_page(0);
        bus.dout_ready = 1'b1;
        base = done_cnt;
        pulse_start(0);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            chk("d3_busy", 32'(busy), 32'(c >= 1 && c <= 8));
            chk("d3_done", 32'(done), 32'(c == 9));
            chk("d3_valid", 32'(bus.dout_valid), 32'(c >= 6 && c <= 8));
            chk("d3_last", 32'(bus.dout_last), 32'(c == 8));
            if (c >= 3 && c <= 5) chk("d3_addrb", 32'(bus.addrb), 32'(c - 3));
            if (c >= 6 && c <= 8) chk("d3_dout", 32'(bus.dout), 32'(18'h11 * (c - 5)));
        end
        chk("d3_queue", 32'(exp_q.size()), 32'd0);

        // Empty page 1: completes without any entry.
        cnt_pg[1] = 5'd0;
        expect_page(1);
        pulse_start(1);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            chk("e0_done", 32'(done), 32'(c == 3));
            chk("e0_enb", 32'(bus.enb), 32'(c <= 2));
            chk("e0_valid", 32'(bus.dout_valid), 32'd0);
        end

        // 31 random entries with ready pattern 1,0,0 repeating.
        fill_random(0, 31);
        expect_page(0);
        base = done_cnt;
        pulse_start(0);
        for (int k = 0; k < 600 && done_cnt == base; k++) begin
            @(posedge clk);
            #1 bus.dout_ready = (k % 3 == 0);
        end
        chk("t31_done", 32'(done_cnt - base), 32'd1);
        chk("t31_all_delivered", 32'(exp_q.size()), 32'd0);
        bus.dout_ready = 1'b1;

        // Long stall mid-READ, with an ignored second start.
        fill_random(1, 20);
        expect_page(1);
        popped = 0;
        base = done_cnt;
        pulse_start(1);
        wait_popped("stall_pre", 2, 50);
        @(posedge clk);
        #1 bus.dout_ready = 1'b0;
        pulse_start(0);
        repeat (19) @(negedge clk);
        chk("stall_busy", 32'(busy), 32'd1);
        chk("stall_addr_lo", 32'(int'(bus.addrb) >= popped + 3), 32'd1);
        chk("stall_addr_hi", 32'(int'(bus.addrb) <= popped + 4), 32'd1);
        @(posedge clk);
        #1 bus.dout_ready = 1'b1;
        wait_done("stall", 200);
        repeat (5) @(negedge clk);
        chk("stall_single_done", 32'(done_cnt - base), 32'd1);
        chk("stall_idle", 32'(busy), 32'd0);

        // Back-to-back pages started from idle.
        fill_random(0, 5);
        fill_random(1, 7);
        expect_page(0);
        pulse_start(0);
        wait_done("b2b_p0", 100);
        expect_page(1);
        pulse_start(1);
        wait_done("b2b_p1", 100);

        // Reset during a 10-entry read, then rerun the same page.
        fill_random(0, 10);
        expect_page(0);
        popped = 0;
        pulse_start(0);
        wait_popped("rst_pre", 3, 50);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 chk_outputs_zero("rst_mid");
        exp_q.delete();
        base = done_cnt;
        @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("rst_no_done", 32'(done_cnt - base), 32'd0);
        chk("rst_idle", 32'(busy), 32'd0);
        expect_page(0);
        pulse_start(0);
        wait_done("rst_rerun", 100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
